bf16_pack: RTL and testbench
============================

# bf16_pack

Pipelined bf16 encoder: takes sign, signed unbiased exponent, a wide unnormalized magnitude and a 4-bit class flag, and produces a packed bf16 word. It normalizes, rounds to nearest-even, saturates to infinity on overflow, flushes to zero on underflow and emits canonical specials. It sits at the output of the KAN datapath arithmetic and is the inverse of the bf16 field/class decoder, using the same `{nan, zero, inf, norm}` flag encoding.

## Interface
- `NUM_WIDTH`, default 16: packed output width.
- `EXP_WIDTH`, default 8: packed exponent field width. Bias is 2^(EXP_WIDTH-1)-1, so 127 at the default.
- `SIG_WIDTH`, default 7: stored fraction width.
- `FLAG_WIDTH`, default 4: class flag width.
- `EXP_IN_WIDTH`, default 10: input exponent width, signed.
- `MAN_WIDTH`, default 16: input magnitude width. Must satisfy MAN_WIDTH ≥ SIG_WIDTH+2.

Ports:
- `i_clk`  in  1  clock. Single clock domain.
- `i_rst`  in  1  synchronous, active-high reset.
- `i_valid`  in  1  input beat valid.
- `o_ready`  out  1  block can accept a beat.
- `i_sign`  in  1  sign.
- `i_exp`  in  EXP_IN_WIDTH  signed exponent. Value = i_man × 2^(i_exp − (MAN_WIDTH−1)).
- `i_man`  in  MAN_WIDTH  unsigned magnitude, not necessarily normalized.
- `i_flag`  in  FLAG_WIDTH  `{nan, zero, inf, norm}`.
- `o_valid`  out  1  output beat valid.
- `i_ready`  in  1  downstream accepts.
- `o_data`  out  NUM_WIDTH  packed bf16.
- `o_inexact`  out  1  the result differs from the exact input value.

## Operation

**Class priority:** nan > inf > zero > norm.
- If the flag is norm and i_man==0, the beat is treated as zero.
- If no flag bit is set, the beat is treated as norm.

**Stage 1 (normalize):**
- lz = leading-zero count of i_man.
- m = i_man << lz.
- e = i_exp − lz.
- All exponent math is done in signed EXP_IN_WIDTH+2 bits. It must never wrap.

**Stage 2 (round):**
- kept = m[MAN_WIDTH−1 -: SIG_WIDTH+1]
- guard = next bit below kept.
- sticky = OR of all remaining lower bits.
- Round up when guard & (sticky | kept[0]).
- If kept overflows on round-up (all ones + 1), then kept = 1000…0 and e = e+1.
- inexact = guard | sticky.

**Stage 3 (pack):**
- b = e + bias.
- nan → 0x7FC0, with sign forced to 0 and inexact=0.
- inf → {sign, 0x7F80 field}, inexact=0.
- zero → {sign, 15'b0}, inexact=0.
- norm with b ≥ 255 → {sign, inf}, inexact=1.
- norm with b ≤ 0 → {sign, 0} (no subnormals), inexact=1.
- Otherwise → {sign, b[7:0], kept[SIG_WIDTH-1:0]}, inexact from stage 2.

**Handshake:**
- A transfer occurs on any edge with valid & ready high.
- Global stall: adv = ~o_valid | i_ready, and o_ready = adv.
- When adv is low, every stage register holds its value.
- A bubble entering the pipe sets that stage's valid bit to 0. Bubbles are not collapsed.
- While o_valid & ~i_ready, o_data and o_inexact stay stable.
- Output order equals input order. No beat is dropped or duplicated.

## Timing
- Latency is 3 cycles. A beat accepted at edge N appears with o_valid=1 after edge N+3, assuming no stall.
- Throughput is one beat per cycle while i_ready=1.
- Reset values: all stage valid bits 0, o_valid=0, o_data=0, o_inexact=0.
- o_ready=1 in the cycle after reset, because o_valid=0.
- Reset asserted mid-stream discards every in-flight beat at the next edge. No partial output appears afterwards.
- Simultaneous input accept and output drain in the same cycle is legal and keeps full throughput.
- i_valid=0 with i_ready=1 drains the pipe one stage per cycle.

## Test plan
1. **Basic pack and normalization:**
   - exp=0, man=0x8000, sign=0, flag=norm → o_data=0x3F80, inexact=0, exactly 3 cycles after accept.
   - exp=15, man=0x0001 → 0x3F80.
   - sign=1, exp=1, man=0xC000 → 0xC040.
2. **Rounding (exp=0):**
   - man=0x8180 → 0x3F82, inexact=1 (tie, odd, rounds up).
   - man=0x8080 → 0x3F80, inexact=1 (tie, even, holds).
   - man=0x8081 → 0x3F81.
   - man=0xFF80 → 0x4000 (carry bumps the exponent).
3. **Range limits:**
   - exp=128, man=0x8000 → 0x7F80, inexact=1.
   - exp=127, man=0xFFFF → 0x7F80.
   - exp=127, man=0x8000 → 0x7F00.
   - exp=−127 → 0x0000; the same with sign=1 → 0x8000.
   - exp=−126, man=0x8000 → 0x0080.
4. **Specials:**
   - flag=nan, sign=1 → 0x7FC0.
   - flag=inf, sign=1 → 0xFF80.
   - flag=zero, sign=1 → 0x8000.
   - flag=norm, man=0 → 0x0000.
   - flags nan|inf both set → 0x7FC0.
5. **Backpressure:**
   - Send 8 back-to-back beats with i_ready low for cycles 4–7 → all 8 outputs arrive in order with none lost.
   - o_data holds steady while stalled.
   - o_ready=0 exactly when o_valid & ~i_ready.
6. **Reset mid-stream:**
   - Send 3 beats, then assert i_rst for one cycle → o_valid=0 and o_data=0 next cycle.
   - No stale beat emerges afterwards.
   - A new beat (exp=0, man=0x8000) → 0x3F80 after 3 cycles.

Source files
------------

// File: rtl/bf16_pack.sv
// bf16_pack: pipelined normalize, round-to-nearest-even and pack into a bf16 word.
// Four register ranks (capture, normalize, round, pack) move together under one global stall.
module bf16_pack #(
    parameter int NUM_WIDTH    = 16,
    parameter int EXP_WIDTH    = 8,
    parameter int SIG_WIDTH    = 7,
    parameter int FLAG_WIDTH   = 4,
    parameter int EXP_IN_WIDTH = 10,
    parameter int MAN_WIDTH    = 16
) (
    input  logic                           i_clk,
    input  logic                           i_rst,
    input  logic                           i_valid,
    output logic                           o_ready,
    input  logic                           i_sign,
    input  logic signed [EXP_IN_WIDTH-1:0] i_exp,
    input  logic [MAN_WIDTH-1:0]           i_man,
    input  logic [FLAG_WIDTH-1:0]          i_flag,
    output logic                           o_valid,
    input  logic                           i_ready,
    output logic [NUM_WIDTH-1:0]           o_data,
    output logic                           o_inexact
);
    localparam int EW   = EXP_IN_WIDTH + 2;
    localparam int LZ_W = $clog2(MAN_WIDTH + 1);
    localparam int BIAS = (1 << (EXP_WIDTH - 1)) - 1;
    localparam int GRD  = MAN_WIDTH - SIG_WIDTH - 2;
    localparam logic signed [EW-1:0] B_MAX = EW'((1 << EXP_WIDTH) - 1);

    typedef enum logic [1:0] {CLS_NORM, CLS_ZERO, CLS_INF, CLS_NAN} cls_e;

    logic adv;
    assign adv     = ~o_valid | i_ready;
    assign o_ready = adv;

    // Flag layout is {nan, zero, inf, norm}; an empty flag means norm.
    logic norm_req;
    cls_e cls0_d;
    always_comb begin
        norm_req = i_flag[0] | ~|i_flag;
        cls0_d   = CLS_ZERO;
        if (i_flag[3])                    cls0_d = CLS_NAN;
        else if (i_flag[1])               cls0_d = CLS_INF;
        else if (norm_req && !i_flag[2])  cls0_d = CLS_NORM;
    end

    logic                           v0_q, sign0_q;
    logic signed [EXP_IN_WIDTH-1:0] exp0_q;
    logic [MAN_WIDTH-1:0]           man0_q;
    cls_e                           cls0_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v0_q <= 1'b0;
        end else if (adv) begin
            v0_q    <= i_valid;
            sign0_q <= i_sign;
            exp0_q  <= i_exp;
            man0_q  <= i_man;
            cls0_q  <= cls0_d;
        end
    end

    function automatic logic [LZ_W-1:0] lead_zeros(input logic [MAN_WIDTH-1:0] v);
        logic [LZ_W-1:0] n;
        n = LZ_W'(MAN_WIDTH);
        for (int i = 0; i < MAN_WIDTH; i++)
            if (v[i]) n = LZ_W'(MAN_WIDTH - 1 - i);
        return n;
    endfunction

    logic [LZ_W-1:0]       lz1;
    logic [MAN_WIDTH-1:0]  man1_d;
    logic signed [EW-1:0]  exp1_d;
    always_comb begin
        lz1    = lead_zeros(man0_q);
        man1_d = man0_q << lz1;
        exp1_d = EW'(exp0_q) - EW'(lz1);
    end

    logic                  v1_q, sign1_q;
    logic signed [EW-1:0]  exp1_q;
    logic [MAN_WIDTH-1:0]  man1_q;
    cls_e                  cls1_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v1_q <= 1'b0;
        end else if (adv) begin
            v1_q    <= v0_q;
            sign1_q <= sign0_q;
            exp1_q  <= exp1_d;
            man1_q  <= man1_d;
            cls1_q  <= cls0_q;
        end
    end

    // A clear hidden bit after normalization can only mean a zero magnitude.
    logic                  guard2, sticky2, round_up2;
    logic [SIG_WIDTH:0]    frac_sum2;
    logic signed [EW-1:0]  exp2_d;
    cls_e                  cls2_d;
    always_comb begin
        guard2    = man1_q[GRD];
        sticky2   = |(man1_q << (SIG_WIDTH + 2));
        round_up2 = guard2 & (sticky2 | man1_q[GRD+1]);
        frac_sum2 = {1'b0, man1_q[MAN_WIDTH-2 -: SIG_WIDTH]} + (SIG_WIDTH+1)'(round_up2);
        exp2_d    = exp1_q + EW'(frac_sum2[SIG_WIDTH]);
        cls2_d    = (cls1_q == CLS_NORM && !man1_q[MAN_WIDTH-1]) ? CLS_ZERO : cls1_q;
    end

    logic                  v2_q, sign2_q, inx2_q;
    logic signed [EW-1:0]  exp2_q;
    logic [SIG_WIDTH-1:0]  frac2_q;
    cls_e                  cls2_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            v2_q <= 1'b0;
        end else if (adv) begin
            v2_q    <= v1_q;
            sign2_q <= sign1_q;
            exp2_q  <= exp2_d;
            frac2_q <= frac_sum2[SIG_WIDTH-1:0];
            inx2_q  <= guard2 | sticky2;
            cls2_q  <= cls2_d;
        end
    end

    logic signed [EW-1:0]  be3;
    logic [NUM_WIDTH-1:0]  data3_d;
    logic                  inx3_d;
    always_comb begin
        be3     = exp2_q + EW'(BIAS);
        data3_d = '0;
        inx3_d  = 1'b0;
        case (cls2_q)
            CLS_NAN:  data3_d = {1'b0, {EXP_WIDTH{1'b1}}, 1'b1, {(SIG_WIDTH-1){1'b0}}};
            CLS_INF:  data3_d = {sign2_q, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
            CLS_ZERO: data3_d = {sign2_q, {(NUM_WIDTH-1){1'b0}}};
            default: begin
                inx3_d = 1'b1;
                if (be3 >= B_MAX) begin
                    data3_d = {sign2_q, {EXP_WIDTH{1'b1}}, {SIG_WIDTH{1'b0}}};
                end else if (be3[EW-1] || be3 == '0) begin
                    data3_d = {sign2_q, {(NUM_WIDTH-1){1'b0}}};
                end else begin
                    data3_d = {sign2_q, be3[EXP_WIDTH-1:0], frac2_q};
                    inx3_d  = inx2_q;
                end
            end
        endcase
    end

    logic                  out_v_q, inx_q;
    logic [NUM_WIDTH-1:0]  data_q;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_v_q <= 1'b0;
            data_q  <= '0;
            inx_q   <= 1'b0;
        end else if (adv) begin
            out_v_q <= v2_q;
            if (v2_q) begin
                data_q <= data3_d;
                inx_q  <= inx3_d;
            end
        end
    end

    assign o_valid   = out_v_q;
    assign o_data    = data_q;
    assign o_inexact = inx_q;
endmodule

// File: tb/tb_bf16_pack.sv
// Bench for bf16_pack: directed spec cases plus random traffic against an arithmetic model.
module tb_bf16_pack;
    logic              clk;
    logic              i_rst, i_valid, i_sign, i_ready;
    logic signed [9:0] i_exp;
    logic [15:0]       i_man;
    logic [3:0]        i_flag;
    logic              o_ready, o_valid, o_inexact;
    logic [15:0]       o_data;

    bf16_pack dut (
        .i_clk(clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
        .i_sign(i_sign), .i_exp(i_exp), .i_man(i_man), .i_flag(i_flag),
        .o_valid(o_valid), .i_ready(i_ready), .o_data(o_data), .o_inexact(o_inexact)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          tests = 0;
    int          fails = 0;
    int          cyc = 0;
    int          n_out = 0;
    logic        lat_chk = 1'b1;
    logic        hold_v = 1'b0;
    logic [16:0] hold_w;
    logic [16:0] sbq[$];
    int          accq[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        tests++;
        assert (obs === exp_v) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    // Value = man * 2^(e-15); round the real value to 8 significant bits, ties to even.
    function automatic logic [16:0] ref_pack(input logic s, input int e, input int man,
                                             input logic [3:0] f);
        int   p, sh, q, rem, half, be;
        logic up;
        if (f[3]) return {1'b0, 16'h7FC0};
        if (f[1]) return {1'b0, s, 15'h7F80};
        if (f[2] || man == 0) return {1'b0, s, 15'h0000};
        p = 0;
        for (int i = 0; i < 16; i++) if (man >= (1 << i)) p = i;
        sh = p - 7;
        up = 1'b0;
        rem = 0;
        if (sh > 0) begin
            q    = man >> sh;
            rem  = man - (q << sh);
            half = 1 << (sh - 1);
            up   = (rem > half) || (rem == half && (q % 2) == 1);
        end else begin
            q = man << (-sh);
        end
        be = e - 15 + p + 127;
        if (up) q++;
        if (q == 256) begin
            q = 128;
            be++;
        end
        if (be >= 255) return {1'b1, s, 15'h7F80};
        if (be <= 0) return {1'b1, s, 15'h0000};
        return {(rem != 0), s, be[7:0], q[6:0]};
    endfunction

    task automatic step(input logic v, input logic s, input int e, input int m,
                        input logic [3:0] f, input logic rdy, input logic r,
                        input logic ovr, input logic [16:0] ovr_w, output logic acc);
        logic [16:0] exp_w;
        int          a;
        @(negedge clk);
        i_rst = r; i_valid = v; i_sign = s; i_exp = e[9:0]; i_man = m[15:0];
        i_flag = f; i_ready = rdy;
        #1;
        acc = 1'b0;
        if (r) begin
            sbq.delete();
            accq.delete();
            hold_v = 1'b0;
        end else begin
            chk("o_ready", o_ready, !(o_valid && !i_ready));
            if (hold_v) chk("hold_stable", {o_inexact, o_data}, hold_w);
            if (o_valid && i_ready) begin
                if (sbq.size() == 0) begin
                    chk("spurious_out", o_valid, 0);
                end else begin
                    exp_w = sbq.pop_front();
                    a = accq.pop_front();
                    n_out++;
                    chk("data", o_data, exp_w[15:0]);
                    chk("inexact", o_inexact, exp_w[16]);
                    if (lat_chk) chk("latency", cyc - a, 4);
                end
            end
            hold_v = o_valid && !i_ready;
            hold_w = {o_inexact, o_data};
            if (v && o_ready) begin
                sbq.push_back(ovr ? ovr_w : ref_pack(s, e, m, f));
                accq.push_back(cyc);
                acc = 1'b1;
            end
        end
        @(posedge clk);
        cyc++;
    endtask

    task automatic idle();
        logic a;
        step(1'b0, 1'b0, 0, 0, 4'h1, 1'b1, 1'b0, 1'b0, 17'h0, a);
    endtask

    task automatic dir(input logic s, input int e, input int m, input logic [3:0] f,
                       input logic [16:0] w);
        logic a;
        step(1'b1, s, e, m, f, 1'b1, 1'b0, 1'b1, w, a);
        chk("dir_accept", a, 1);
    endtask

    task automatic drain();
        for (int k = 0; k < 30 && sbq.size() != 0; k++) idle();
        chk("drain", sbq.size(), 0);
    endtask

    task automatic post_reset_chk();
        #2;
        chk("rst_o_valid", o_valid, 0);
        chk("rst_o_data", o_data, 0);
        chk("rst_o_inexact", o_inexact, 0);
        chk("rst_o_ready", o_ready, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic acc;
        int   k, n0;
        i_rst = 1'b1; i_valid = 1'b0; i_sign = 1'b0; i_exp = '0; i_man = '0;
        i_flag = 4'h1; i_ready = 1'b1;
        step(1'b0, 1'b0, 0, 0, 4'h1, 1'b1, 1'b1, 1'b0, 17'h0, acc);
        step(1'b0, 1'b0, 0, 0, 4'h1, 1'b1, 1'b1, 1'b0, 17'h0, acc);
        post_reset_chk();

        // basic pack, normalization, rounding, range limits, specials
        dir(0, 0,    'h8000, 4'b0001, {1'b0, 16'h3F80});
        dir(0, 15,   'h0001, 4'b0001, {1'b0, 16'h3F80});
        dir(1, 1,    'hC000, 4'b0001, {1'b0, 16'hC040});
        dir(0, 0,    'h8180, 4'b0001, {1'b1, 16'h3F82});
        dir(0, 0,    'h8080, 4'b0001, {1'b1, 16'h3F80});
        dir(0, 0,    'h8081, 4'b0001, {1'b1, 16'h3F81});
        dir(0, 0,    'hFF80, 4'b0001, {1'b1, 16'h4000});
        dir(0, 128,  'h8000, 4'b0001, {1'b1, 16'h7F80});
        dir(0, 127,  'hFFFF, 4'b0001, {1'b1, 16'h7F80});
        dir(0, 127,  'h8000, 4'b0001, {1'b0, 16'h7F00});
        dir(0, -127, 'h8000, 4'b0001, {1'b1, 16'h0000});
        dir(1, -127, 'h8000, 4'b0001, {1'b1, 16'h8000});
        dir(0, -126, 'h8000, 4'b0001, {1'b0, 16'h0080});
        dir(1, 0,    'h8000, 4'b1000, {1'b0, 16'h7FC0});
        dir(1, 0,    'h8000, 4'b0010, {1'b0, 16'hFF80});
        dir(1, 0,    'h8000, 4'b0100, {1'b0, 16'h8000});
        dir(0, 0,    'h0000, 4'b0001, {1'b0, 16'h0000});
        dir(0, 0,    'h8000, 4'b1010, {1'b0, 16'h7FC0});
        dir(0, 0,    'h8000, 4'b0000, {1'b0, 16'h3F80});
        drain();

        // backpressure: 8 beats, downstream stalls for cycles 4..7
        lat_chk = 1'b0;
        k = 0;
        n0 = n_out;
        for (int c = 0; c < 40 && (k < 8 || sbq.size() != 0); c++) begin
            step(k < 8, k[0], k - 3, 'h8000 + k * 'h0111, 4'b0001,
                 !(c >= 4 && c <= 7), 1'b0, 1'b0, 17'h0, acc);
            if (acc) k++;
        end
        chk("bp_beats_out", n_out - n0, 8);

        // reset mid-stream
        lat_chk = 1'b1;
        for (int j = 0; j < 3; j++)
            step(1'b1, 1'b0, j, 'h9000 + j, 4'b0001, 1'b1, 1'b0, 1'b0, 17'h0, acc);
        step(1'b0, 1'b0, 0, 0, 4'h1, 1'b1, 1'b1, 1'b0, 17'h0, acc);
        post_reset_chk();
        n0 = n_out;
        for (int j = 0; j < 6; j++) idle();
        chk("no_stale_beats", n_out - n0, 0);
        dir(0, 0, 'h8000, 4'b0001, {1'b0, 16'h3F80});
        drain();

        // random traffic with random backpressure
        lat_chk = 1'b0;
        for (int j = 0; j < 400; j++) begin
            int   e, m, sel;
            logic [3:0] f;
            e   = int'($urandom_range(0, 300)) - 150;
            m   = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 255))
                                              : int'($urandom_range(0, 65535));
            sel = int'($urandom_range(0, 9));
            f   = (sel == 0) ? 4'($urandom) : (sel == 1) ? 4'b0000 : 4'b0001;
            step($urandom_range(0, 4) != 0, 1'($urandom), e, m, f,
                 $urandom_range(0, 3) != 0, 1'b0, 1'b0, 17'h0, acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
